// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM state type, default parameters and counter width for mem_ctrl.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int ADDR_W_DEF      = 16;
    localparam int DEPTH_DEF       = 4096;
    localparam int WAIT_STATES_DEF = 1;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_W storage, synchronous write, asynchronous read, no reset.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none; the owner arbitrates the single write port.
module mem_array
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: word memory with CPU req/ack FSM and bench-load port; MEM_CTRL_BOUNDS_CHECK_EN enables range checking.
// Latency: ack is seen WAIT_STATES+1 edges after the req-sampling edge; one access per WAIT_STATES+2 cycles.
// Backpressure: req is sampled only in IDLE, so a requester holds req (or re-issues) until ack.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] maxmem
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WS_CNT = CNT_W'(WAIT_STATES);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              start;
    logic              go_resp;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_oob;
    logic              load_oob;
    logic              load_wr;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic              unused_addr_bits;

    assign maxmem = ADDR_W'(DEPTH - 1);

    assign start   = (state == IDLE) && !load_en && req;
    assign go_resp = (start && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (cnt == CNT_W'(1)));

    // With zero wait states the access happens on the sampling edge itself,
    // so the live CPU inputs feed the array instead of the latched copies.
    assign acc_we    = (state == IDLE) ? we    : lat_we;
    assign acc_addr  = (state == IDLE) ? addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? wdata : lat_wdata;

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    assign acc_oob  = {1'b0, acc_addr}  >= DEPTH_L;
    assign load_oob = {1'b0, load_addr} >= DEPTH_L;
`else
    assign acc_oob  = 1'b0;
    assign load_oob = 1'b0;
`endif

    // Index bits above log2(DEPTH) are dropped, giving wrap-around when unchecked.
    assign unused_addr_bits = ^{acc_addr, load_addr};

    // Load writes only land while idle; a CPU access cannot coincide since it needs load_en low.
    assign load_wr   = (state == IDLE) && load_en && load_we && !load_oob;
    assign arr_we    = load_wr || (go_resp && acc_we && !acc_oob);
    assign arr_waddr = load_wr ? load_addr[IDX_W-1:0] : acc_addr[IDX_W-1:0];
    assign arr_wdata = load_wr ? load_data : acc_wdata;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (acc_addr[IDX_W-1:0]),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            ack <= go_resp;
            err <= go_resp && acc_oob;
            if (go_resp && !acc_we) begin
                rdata <= acc_oob ? '0 : arr_rdata;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        lat_we    <= we;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        cnt       <= WS_CNT;
                        busy      <= 1'b1;
                        state     <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus with a read/write scoreboard against a shadow memory model.
// Covers bench load, CPU access, wait-state throughput, bounds/wrap, reset mid-access and load during busy.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_en = 1'b0, load_we = 1'b0;
    logic [15:0] load_addr = '0, load_data = '0;
    logic        req = 1'b0, we = 1'b0;
    logic [15:0] addr = '0, wdata = '0;
    logic        ack, busy, err;
    logic [15:0] rdata, maxmem;

    logic        l3_en = 1'b0, l3_we = 1'b0;
    logic [15:0] l3_addr = '0, l3_data = '0;
    logic        req3 = 1'b0, we3 = 1'b0;
    logic [15:0] addr3 = '0, wdata3 = '0;
    logic        ack3, busy3, err3;
    logic [15:0] rdata3, maxmem3;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_mem [int];
    logic [15:0] last_rdata = 16'h0;

    always #5 clk = ~clk;

    mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy(busy), .err(err), .maxmem(maxmem)
    );

    mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset),
        .load_en(l3_en), .load_we(l3_we), .load_addr(l3_addr), .load_data(l3_data),
        .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
        .ack(ack3), .rdata(rdata3), .busy(busy3), .err(err3), .maxmem(maxmem3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit oob(input logic [15:0] a);
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
        return a >= 16'h1000;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int idx(input logic [15:0] a);
        return int'(a[11:0]);
    endfunction

    task automatic bench_load(input logic [15:0] a, input logic [15:0] d, input string tag);
        @(negedge clk);
        load_en = 1; load_we = 1; load_addr = a; load_data = d;
        req = 1; we = 0; addr = a;
        if (!oob(a)) model_mem[idx(a)] = d;
        @(posedge clk); #1;
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic cpu_access(input bit w, input logic [15:0] a, input logic [15:0] d,
                              input bit load_busy, input string tag);
        exp_t e;
        int   n;
        @(negedge clk);
        req = 1; we = w; addr = a; wdata = d;
        if (w) begin
            if (!oob(a)) model_mem[idx(a)] = d;
            e.data = last_rdata;
        end else begin
            e.data = oob(a) ? 16'h0 : model_mem[idx(a)];
        end
        e.err = oob(a);
        sb.push_back(e);
        last_rdata = e.data;
        @(posedge clk); #1;
        req = 0; we = ~w; addr = ~a; wdata = ~d;
        check({tag, "_busy_hi"}, 32'(busy), 32'd1);
        if (load_busy) begin
            load_en = 1; load_we = 1; load_addr = a; load_data = ~d;
        end
        n = 0;
        while (ack !== 1'b1 && n < 32) begin
            @(posedge clk); #1;
            n++;
        end
        load_en = 0; load_we = 0;
        check({tag, "_lat"}, 32'(n + 1), 32'd2);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_rdata"}, 32'(rdata), 32'(e.data));
            check({tag, "_err"}, 32'(err), 32'(e.err));
        end
        @(posedge clk); #1;
        check({tag, "_ack_lo"}, 32'(ack), 32'd0);
        check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_t[$];
        int gaps[$];
        int busy_low;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("maxmem", 32'(maxmem), 32'h0FFF);
        @(negedge clk);
        reset = 1;

        // Bench load with req asserted: req ignored, no ack
        bench_load(16'h0000, 16'hB00C, "load0");
        bench_load(16'h0001, 16'hEA00, "load1");
        @(negedge clk);
        load_en = 0; load_we = 0; req = 0;
        cpu_access(0, 16'h0001, 16'h0, 0, "rd1");
        cpu_access(0, 16'h0000, 16'h0, 0, "rd0");

        // Write then read top word
        cpu_access(1, 16'h0FFF, 16'h1234, 0, "wr_fff");
        cpu_access(0, 16'h0FFF, 16'h0, 0, "rd_fff");
        check("maxmem_run", 32'(maxmem), 32'h0FFF);

        // Bounds / wrap-around
        cpu_access(1, 16'h0005, 16'h0505, 0, "wr_5");
        cpu_access(1, 16'h1005, 16'h5A5A, 0, "wr_1005");
        cpu_access(0, 16'h0005, 16'h0, 0, "rd_5");
        cpu_access(0, 16'h1000, 16'h0, 0, "rd_1000");

        // Reset during WAIT of a write
        cpu_access(1, 16'h0010, 16'h3C3C, 0, "pre10");
        cpu_access(0, 16'h0FFF, 16'h0, 0, "rd_nz");
        @(negedge clk);
        req = 1; we = 1; addr = 16'h0010; wdata = 16'hFFFF;
        @(posedge clk); #1;
        req = 0;
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        reset = 0;
        #1;
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        last_rdata = 16'h0;
        @(posedge clk); #1;
        reset = 1;
        cpu_access(0, 16'h0010, 16'h0, 0, "rd10_post_rst");

        // Load during busy is dropped
        cpu_access(1, 16'h0020, 16'h00AA, 1, "wr20_loadbusy");
        cpu_access(0, 16'h0020, 16'h0, 0, "rd20");

        // Wait-state throughput on the WAIT_STATES=3 instance, req held high
        @(negedge clk);
        req3 = 1; we3 = 1; addr3 = 16'h0007; wdata3 = 16'h7777;
        busy_low = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ack3 === 1'b1) begin
                ack_t.push_back(c);
                if (ack_t.size() > 1) begin
                    gaps.push_back(busy_low);
                    check("ws3_rdata", 32'(rdata3), 32'h7777);
                end
                busy_low = 0;
                we3 = 0;
            end else if (busy3 === 1'b0) begin
                busy_low++;
            end
        end
        req3 = 0;
        check("ws3_ack_count", 32'(ack_t.size()), 32'd4);
        if (ack_t.size() > 0) check("ws3_first_ack", 32'(ack_t[0]), 32'd4);
        for (int i = 0; i + 1 < ack_t.size(); i++) begin
            check("ws3_period", 32'(ack_t[i+1] - ack_t[i]), 32'd5);
        end
        foreach (gaps[i]) check("ws3_busy_gap", 32'(gaps[i]), 32'd1);

        repeat (6) @(posedge clk);
        #1;
        check("ws3_idle", 32'(busy3), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters SHALL be as follows:
- DATA_W, 16: word width.
- ADDR_W, 16: address width.
- DEPTH, 4096: word count, power of two, at most 2**ADDR_W.
- WAIT_STATES, 1: extra cycles per access, range 0..15.
REQ-002 Ports SHALL be as follows:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  bench-load port owns the array.
- load_we  in  1  bench write strobe.
- load_addr  in  ADDR_W  bench address.
- load_data  in  DATA_W  bench write data.
- req  in  1  CPU access request.
- we  in  1  CPU write (1) or read (0).
- addr  in  ADDR_W  CPU address.
- wdata  in  DATA_W  CPU write data.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data, valid with ack.
- busy  out  1  transaction in flight.
- err  out  1  out-of-range access, valid with ack.
- maxmem  out  ADDR_W  constant DEPTH-1.

Function
REQ-003 FSM SHALL have states IDLE, WAIT and RESP; busy SHALL be 1 in WAIT and RESP only.
REQ-004 In IDLE with load_en=0 and req=1 at posedge, the block SHALL latch we, addr and wdata, load the counter with WAIT_STATES, and enter WAIT (RESP if WAIT_STATES=0).
REQ-005 WAIT SHALL decrement the counter each cycle and enter RESP at the posedge where the counter is 0.
REQ-006 The array access SHALL occur at the posedge entering RESP: a write stores the latched wdata, a read registers the array word into rdata.
REQ-007 ack SHALL be 1 for exactly the RESP cycle; RESP SHALL always return to IDLE.
REQ-008 Access latency from the req-sampling edge to ack SHALL be WAIT_STATES+1 cycles; peak throughput SHALL be one access per WAIT_STATES+2 cycles.
REQ-009 rdata SHALL hold its last value outside RESP; on writes rdata SHALL be unchanged.
REQ-010 CPU inputs SHALL be ignored outside IDLE; changing addr, we or wdata mid-transaction SHALL have no effect.
REQ-011 With load_en=1 in IDLE, load_we=1 SHALL write load_data to load_addr at posedge; req SHALL be ignored and no ack SHALL be produced.
REQ-012 load_en asserted while busy SHALL NOT abort the transaction; load writes during busy SHALL be dropped.
REQ-013 Without the bounds check, the array index SHALL be the low log2(DEPTH) address bits (wrap-around), for both ports.

Reset
REQ-014 reset=0 SHALL asynchronously force IDLE, counter=0, ack=0, busy=0, err=0 and rdata=0; array contents SHALL be retained.
REQ-015 Reset during WAIT SHALL drop the pending write with no array change; after release, the FSM SHALL accept a new req on the first posedge.

Configuration
REQ-016 The macro MEM_CTRL_BOUNDS_CHECK_EN SHALL control bounds checking:
- Defined: a CPU or load address of DEPTH or above SHALL suppress the write; a CPU read SHALL return rdata=0; err SHALL be 1 with ack.
- Undefined: err SHALL be tied 0 and REQ-013 wrap-around SHALL apply.

Structure
REQ-017 The package mem_ctrl_pkg SHALL hold the state enum, the default parameter constants and the counter width (4).
REQ-018 Storage SHALL be the sub-module mem_array, with synchronous write and asynchronous read, instantiated once; arbitration and the FSM SHALL live in mem_ctrl.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Bench load: load_en=1, write 0xB00C to 0 and 0xEA00 to 1, then load_en=0; CPU read at 1 -> ack after 2 cycles, rdata=0xEA00.
- Write then read: CPU write 0x1234 to 0x0FFF, then read 0x0FFF -> rdata=0x1234; maxmem=0x0FFF throughout.
- Wait states: WAIT_STATES=3, req held high -> ack every 5 cycles, busy low exactly 1 cycle between acks.
- Bounds: with MEM_CTRL_BOUNDS_CHECK_EN, read 0x1000 -> ack, err=1, rdata=0; without it, write 0x1005 then read 0x0005 -> same data, err=0.
- Reset mid-operation: reset=0 during WAIT of a write of 0xFFFF to 0x10 -> ack=0 and busy=0 immediately; a later read of 0x10 returns the prior value.
- Load during busy: load_en=1 and load_we=1 to the same address during a CPU write of 0x00AA -> CPU write completes, location reads 0x00AA.
